// File: rtl/aes_job_ctrl_if.sv
// Handshake bundle between the AES job sequencer and its surroundings.
// master drives the stream inputs of the sequencer; slave is the sequencer itself.
interface aes_job_ctrl_if;
  logic [31:0]  cntrl_tdata;
  logic         cntrl_tvalid;
  logic         cntrl_tlast;
  logic         cntrl_tready;
  logic [255:0] aes_key;
  logic         key_loaded;
  logic         in_tvalid;
  logic         in_tlast;
  logic         in_tready;
  logic         fifo_empty;
  logic         fifo_tlast;
  logic         fifo_rd_en;
  logic         s2mm_tvalid;
  logic         s2mm_tready;
  logic [31:0]  sts_tdata;
  logic         sts_tvalid;
  logic         sts_tlast;
  logic         sts_tready;
  logic         err;

  modport master (
    output cntrl_tdata, cntrl_tvalid, cntrl_tlast, in_tvalid, in_tlast,
           fifo_empty, fifo_tlast, s2mm_tready, sts_tready,
    input  cntrl_tready, aes_key, key_loaded, in_tready, fifo_rd_en,
           s2mm_tvalid, sts_tdata, sts_tvalid, sts_tlast, err
  );

  modport slave (
    input  cntrl_tdata, cntrl_tvalid, cntrl_tlast, in_tvalid, in_tlast,
           fifo_empty, fifo_tlast, s2mm_tready, sts_tready,
    output cntrl_tready, aes_key, key_loaded, in_tready, fifo_rd_en,
           s2mm_tvalid, sts_tdata, sts_tvalid, sts_tlast, err
  );
endinterface

// File: rtl/aes_job_ctrl.sv
// AES-256 job sequencer: key parsing/commit, mm2s credit gating,
// s2mm pop gating and one 5-word status packet per output packet.
module aes_job_ctrl #(
  parameter int C_FIFO_DEPTH = 256,
  parameter int C_CNT_W      = 9,
  parameter int C_STS_DEPTH  = 4
) (
  input  logic          m_axi_mm2s_aclk,
  input  logic          rst,
  aes_job_ctrl_if.slave bus
);
  localparam int SQ_AW = $clog2(C_STS_DEPTH);
  localparam logic [C_CNT_W-1:0] CREDIT_MAX = C_CNT_W'(C_FIFO_DEPTH);
  localparam logic [C_CNT_W-1:0] CNT_ONE    = C_CNT_W'(1);
  localparam logic [SQ_AW:0]     PTR_ONE    = (SQ_AW+1)'(1);

  typedef enum logic [1:0] {C_IDLE, C_KEY, C_DRAIN, C_COMMIT} ctrl_state_t;
  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3, S_W4} sts_state_t;

  ctrl_state_t        ctrl_state_reg;
  logic [2:0]         kidx_reg;
  logic [255:0]       shadow_reg;
  logic [255:0]       aes_key_reg;
  logic               key_loaded_reg;
  logic               err_reg;
  logic               cntrl_tready_reg;
  logic [C_CNT_W-1:0] outstanding_reg;
  logic               pkt_open_reg;
  logic [15:0]        beat_cnt_reg;
  logic [15:0]        sq_mem [C_STS_DEPTH];
  logic [SQ_AW:0]     sq_wr_ptr_reg;
  logic [SQ_AW:0]     sq_rd_ptr_reg;
  sts_state_t         sts_state_reg;
  logic [31:0]        sts_tdata_reg;
  logic               sts_tvalid_reg;
  logic               sts_tlast_reg;

  logic        cntrl_hs, in_beat, pop, sts_hs;
  logic        sq_empty, sq_full, pipe_idle;
  logic        in_tready_int, s2mm_tvalid_int;
  logic [15:0] beat_cnt_inc;

  assign sq_empty        = (sq_wr_ptr_reg == sq_rd_ptr_reg);
  assign sq_full         = (sq_wr_ptr_reg[SQ_AW] != sq_rd_ptr_reg[SQ_AW]) &&
                           (sq_wr_ptr_reg[SQ_AW-1:0] == sq_rd_ptr_reg[SQ_AW-1:0]);
  assign in_tready_int   = key_loaded_reg && (outstanding_reg < CREDIT_MAX) &&
                           (ctrl_state_reg != C_COMMIT);
  assign in_beat         = bus.in_tvalid && in_tready_int;
  // A full status queue stops pops, so every finished packet has a slot.
  assign s2mm_tvalid_int = !bus.fifo_empty && !sq_full;
  assign pop             = s2mm_tvalid_int && bus.s2mm_tready;
  assign beat_cnt_inc    = (beat_cnt_reg == 16'hFFFF) ? 16'hFFFF : beat_cnt_reg + 16'd1;
  assign cntrl_hs        = bus.cntrl_tvalid && cntrl_tready_reg;
  assign sts_hs          = sts_tvalid_reg && bus.sts_tready;
  assign pipe_idle       = (outstanding_reg == '0) && !pkt_open_reg && sq_empty;

  assign bus.cntrl_tready = cntrl_tready_reg;
  assign bus.aes_key      = aes_key_reg;
  assign bus.key_loaded   = key_loaded_reg;
  assign bus.err          = err_reg;
  assign bus.in_tready    = in_tready_int;
  assign bus.s2mm_tvalid  = s2mm_tvalid_int;
  assign bus.fifo_rd_en   = pop;
  assign bus.sts_tdata    = sts_tdata_reg;
  assign bus.sts_tvalid   = sts_tvalid_reg;
  assign bus.sts_tlast    = sts_tlast_reg;

  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (rst) begin
      ctrl_state_reg   <= C_IDLE;
      kidx_reg         <= '0;
      shadow_reg       <= '0;
      aes_key_reg      <= '0;
      key_loaded_reg   <= 1'b0;
      err_reg          <= 1'b0;
      cntrl_tready_reg <= 1'b0;
    end else begin
      cntrl_tready_reg <= (ctrl_state_reg != C_COMMIT);
      case (ctrl_state_reg)
        C_IDLE: begin
          if (cntrl_hs && !bus.cntrl_tlast) begin
            kidx_reg       <= '0;
            ctrl_state_reg <= (bus.cntrl_tdata[31:28] == 4'hA) ? C_KEY : C_DRAIN;
          end else if (cntrl_hs && bus.cntrl_tdata[31:28] == 4'hA) begin
            err_reg <= 1'b1;
          end
        end
        C_KEY: begin
          if (cntrl_hs) begin
            for (int i = 0; i < 8; i++) begin
              if (kidx_reg == 3'(i)) shadow_reg[255-32*i -: 32] <= bus.cntrl_tdata;
            end
            kidx_reg <= kidx_reg + 3'd1;
            if (kidx_reg == 3'd7) begin
              if (bus.cntrl_tlast) begin
                ctrl_state_reg   <= C_COMMIT;
                cntrl_tready_reg <= 1'b0;
              end else begin
                err_reg        <= 1'b1;
                ctrl_state_reg <= C_DRAIN;
              end
            end else if (bus.cntrl_tlast) begin
              err_reg        <= 1'b1;
              shadow_reg     <= '0;
              ctrl_state_reg <= C_IDLE;
            end
          end
        end
        C_DRAIN: begin
          if (cntrl_hs && bus.cntrl_tlast) ctrl_state_reg <= C_IDLE;
        end
        C_COMMIT: begin
          if (pipe_idle) begin
            aes_key_reg      <= shadow_reg;
            key_loaded_reg   <= 1'b1;
            ctrl_state_reg   <= C_IDLE;
            cntrl_tready_reg <= 1'b1;
          end
        end
        default: ctrl_state_reg <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (rst) begin
      outstanding_reg <= '0;
      pkt_open_reg    <= 1'b0;
      beat_cnt_reg    <= '0;
      sq_wr_ptr_reg   <= '0;
    end else begin
      if (in_beat && !pop) begin
        outstanding_reg <= outstanding_reg + CNT_ONE;
      end else if (pop && !in_beat && outstanding_reg != '0) begin
        outstanding_reg <= outstanding_reg - CNT_ONE;
      end
      if (in_beat) pkt_open_reg <= !bus.in_tlast;
      if (pop) begin
        if (bus.fifo_tlast) begin
          beat_cnt_reg  <= '0;
          sq_wr_ptr_reg <= sq_wr_ptr_reg + PTR_ONE;
        end else begin
          beat_cnt_reg <= beat_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (pop && bus.fifo_tlast) sq_mem[sq_wr_ptr_reg[SQ_AW-1:0]] <= beat_cnt_inc;
  end

  // The queue head stays put until the last status word is accepted.
  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (rst) begin
      sts_state_reg  <= S_IDLE;
      sts_tdata_reg  <= '0;
      sts_tvalid_reg <= 1'b0;
      sts_tlast_reg  <= 1'b0;
      sq_rd_ptr_reg  <= '0;
    end else begin
      case (sts_state_reg)
        S_IDLE: begin
          if (!sq_empty) begin
            sts_tdata_reg  <= 32'h5000_0000 | {16'h0, sq_mem[sq_rd_ptr_reg[SQ_AW-1:0]]};
            sts_tvalid_reg <= 1'b1;
            sts_state_reg  <= S_W0;
          end
        end
        S_W0: begin
          if (sts_hs) begin
            sts_tdata_reg <= '0;
            sts_state_reg <= S_W1;
          end
        end
        S_W1: if (sts_hs) sts_state_reg <= S_W2;
        S_W2: if (sts_hs) sts_state_reg <= S_W3;
        S_W3: begin
          if (sts_hs) begin
            sts_tlast_reg <= 1'b1;
            sts_state_reg <= S_W4;
          end
        end
        S_W4: begin
          if (sts_hs) begin
            sts_tvalid_reg <= 1'b0;
            sts_tlast_reg  <= 1'b0;
            sq_rd_ptr_reg  <= sq_rd_ptr_reg + PTR_ONE;
            sts_state_reg  <= S_IDLE;
          end
        end
        default: sts_state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed bench for aes_job_ctrl: models the datapath FIFO as a queue of
// tlast bits and collects status words for comparison against hand-derived values.
module tb_aes_job_ctrl;
  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  aes_job_ctrl_if bus();

  aes_job_ctrl #(.C_FIFO_DEPTH(256), .C_CNT_W(9), .C_STS_DEPTH(4)) dut (
    .m_axi_mm2s_aclk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [255:0] KEY1 =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] KEY2 =
    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

  logic [31:0] key1_words [8] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                                  32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
  logic [31:0] key2_words [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                  32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

  int checks = 0;
  int failures = 0;
  int beats_sent = 0;
  int pkt_len = 1;
  bit fifo_q[$];
  logic [32:0] sts_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Datapath stand-in: zero-latency FIFO of tlast bits, plus status capture.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
    end else begin
      if (bus.in_tvalid && bus.in_tready) fifo_q.push_back(bus.in_tlast);
      if (bus.fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (bus.sts_tvalid && bus.sts_tready) begin
        sts_q.push_back({bus.sts_tlast, bus.sts_tdata});
        if (bus.sts_tlast) $display("status packet end, words captured=%0d", sts_q.size());
      end
    end
  end

  always @(negedge clk) begin
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_tlast = (fifo_q.size() != 0) ? fifo_q[0] : 1'b0;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ctrl(input logic [31:0] data, input logic last);
    logic rdy;
    int n;
    n = 0;
    bus.cntrl_tdata  = data;
    bus.cntrl_tlast  = last;
    bus.cntrl_tvalid = 1'b1;
    do begin
      rdy = bus.cntrl_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    bus.cntrl_tvalid = 1'b0;
    bus.cntrl_tlast  = 1'b0;
    $display("ctrl beat data=%h last=%0d accepted=%0d", data, last, rdy);
    check("ctrl_accept", 256'(rdy), 256'(1'b1));
  endtask

  task automatic drive_in(input int target, input int budget);
    logic rdy;
    int n;
    n = 0;
    while (beats_sent < target && n < budget) begin
      bus.in_tvalid = 1'b1;
      bus.in_tlast  = (beats_sent == pkt_len - 1);
      rdy = bus.in_tready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) beats_sent++;
    end
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
    $display("in burst: beats_sent=%0d of %0d", beats_sent, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [32:0] exp_w;
    bus.cntrl_tdata = '0; bus.cntrl_tvalid = 1'b0; bus.cntrl_tlast = 1'b0;
    bus.in_tvalid = 1'b0; bus.in_tlast = 1'b0;
    bus.s2mm_tready = 1'b0; bus.sts_tready = 1'b0;

    // Reset state, and no input credit before a key exists
    rst = 1'b1;
    bus.in_tvalid = 1'b1;
    wait_cycles(3);
    check("rst_aes_key", bus.aes_key, 256'h0);
    check("rst_key_loaded", 256'(bus.key_loaded), 256'(1'b0));
    check("rst_err", 256'(bus.err), 256'(1'b0));
    check("rst_sts_tvalid", 256'(bus.sts_tvalid), 256'(1'b0));
    check("rst_cntrl_tready", 256'(bus.cntrl_tready), 256'(1'b0));
    check("rst_s2mm_tvalid", 256'(bus.s2mm_tvalid), 256'(1'b0));
    rst = 1'b0;
    wait_cycles(3);
    check("nokey_in_tready", 256'(bus.in_tready), 256'(1'b0));
    check("nokey_key_loaded", 256'(bus.key_loaded), 256'(1'b0));
    check("idle_cntrl_tready", 256'(bus.cntrl_tready), 256'(1'b1));
    bus.in_tvalid = 1'b0;

    // Full key packet; commit one cycle after tlast
    send_ctrl(32'hA000_0000, 1'b0);
    for (int k = 0; k < 8; k++) send_ctrl(key1_words[k], k == 7);
    check("key_before_commit", bus.aes_key, 256'h0);
    check("commit_tready_low", 256'(bus.cntrl_tready), 256'(1'b0));
    wait_cycles(1);
    check("key1", bus.aes_key, KEY1);
    check("key1_loaded", 256'(bus.key_loaded), 256'(1'b1));
    check("key1_in_tready", 256'(bus.in_tready), 256'(1'b1));

    // Key arrives while a 4-beat job is held in the FIFO
    sts_q.delete();
    bus.s2mm_tready = 1'b0;
    bus.sts_tready  = 1'b1;
    pkt_len = 4; beats_sent = 0;
    drive_in(4, 20);
    check("job4_beats", 256'(beats_sent), 256'(4));
    send_ctrl(32'hA000_0000, 1'b0);
    for (int k = 0; k < 8; k++) send_ctrl(key2_words[k], k == 7);
    wait_cycles(5);
    check("stall_cntrl_tready", 256'(bus.cntrl_tready), 256'(1'b0));
    check("stall_key", bus.aes_key, KEY1);
    check("stall_in_tready", 256'(bus.in_tready), 256'(1'b0));
    bus.s2mm_tready = 1'b1;
    n = 0;
    while (bus.aes_key !== KEY2 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check("key2", bus.aes_key, KEY2);
    check("key2_after_status", 256'(sts_q.size()), 256'(5));
    check("job4_w0", 256'(sts_q[0]), 256'(33'h0_5000_0004));
    check("job4_w4", 256'(sts_q[4]), 256'(33'h1_0000_0000));

    // Non-key packet is drained without error
    send_ctrl(32'h3000_0000, 1'b0);
    send_ctrl(32'h0000_0001, 1'b0);
    send_ctrl(32'h0000_0002, 1'b1);
    wait_cycles(1);
    check("drain_err", 256'(bus.err), 256'(1'b0));
    check("drain_key", bus.aes_key, KEY2);
    check("drain_cntrl_tready", 256'(bus.cntrl_tready), 256'(1'b1));

    // Short key packet: tlast on the third key word
    send_ctrl(32'hA000_0000, 1'b0);
    send_ctrl(32'hDEAD_BEEF, 1'b0);
    send_ctrl(32'hCAFE_F00D, 1'b0);
    send_ctrl(32'h1234_5678, 1'b1);
    wait_cycles(2);
    check("short_err", 256'(bus.err), 256'(1'b1));
    check("short_key", bus.aes_key, KEY2);
    check("short_cntrl_tready", 256'(bus.cntrl_tready), 256'(1'b1));

    // 300-beat job against a blocked s2mm: credit stops at 256
    sts_q.delete();
    bus.s2mm_tready = 1'b0;
    pkt_len = 300; beats_sent = 0;
    drive_in(300, 300);
    check("credit_limit", 256'(beats_sent), 256'(256));
    check("credit_in_tready", 256'(bus.in_tready), 256'(1'b0));
    check("credit_s2mm_tvalid", 256'(bus.s2mm_tvalid), 256'(1'b1));
    bus.s2mm_tready = 1'b1;
    drive_in(300, 400);
    check("job300_beats", 256'(beats_sent), 256'(300));
    n = 0;
    while (sts_q.size() < 5 && n < 600) begin
      wait_cycles(1);
      n++;
    end
    check("job300_w0", 256'(sts_q[0]), 256'(33'h0_5000_012C));
    check("job300_w4", 256'(sts_q[4]), 256'(33'h1_0000_0000));

    // Five 1-beat packets with status stalled: queue fills, fifth beat held
    sts_q.delete();
    bus.sts_tready  = 1'b0;
    bus.s2mm_tready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pkt_len = 1; beats_sent = 0;
      drive_in(1, 20);
    end
    wait_cycles(5);
    check("sq_full_s2mm_tvalid", 256'(bus.s2mm_tvalid), 256'(1'b0));
    check("sq_full_fifo_held", 256'(fifo_q.size()), 256'(1));
    check("sts_hold_valid", 256'(bus.sts_tvalid), 256'(1'b1));
    check("sts_hold_data", 256'(bus.sts_tdata), 256'(32'h5000_0001));
    check("sts_hold_last", 256'(bus.sts_tlast), 256'(1'b0));
    bus.sts_tready = 1'b1;
    n = 0;
    while (sts_q.size() < 25 && n < 300) begin
      wait_cycles(1);
      n++;
    end
    check("sts_word_count", 256'(sts_q.size()), 256'(25));
    for (int i = 0; i < 25; i++) begin
      exp_w = (i % 5 == 0) ? 33'h0_5000_0001 : ((i % 5 == 4) ? 33'h1_0000_0000 : 33'h0);
      check($sformatf("sts_w%0d", i), 256'(sts_q[i]), 256'(exp_w));
    end

    // Reset in the middle of a status packet drops it entirely
    sts_q.delete();
    bus.sts_tready = 1'b0;
    pkt_len = 1; beats_sent = 0;
    drive_in(1, 20);
    wait_cycles(3);
    check("pre_rst_sts_valid", 256'(bus.sts_tvalid), 256'(1'b1));
    rst = 1'b1;
    wait_cycles(1);
    check("mid_rst_sts_valid", 256'(bus.sts_tvalid), 256'(1'b0));
    check("mid_rst_key", bus.aes_key, 256'h0);
    check("mid_rst_key_loaded", 256'(bus.key_loaded), 256'(1'b0));
    check("mid_rst_err", 256'(bus.err), 256'(1'b0));
    check("mid_rst_in_tready", 256'(bus.in_tready), 256'(1'b0));
    rst = 1'b0;
    bus.sts_tready = 1'b1;
    wait_cycles(10);
    check("post_rst_no_status", 256'(sts_q.size()), 256'(0));
    check("post_rst_sts_valid", 256'(bus.sts_tvalid), 256'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
